// File: rtl/vjtag_cmd_exec_if.sv
// Signal bundle between the JTAG command executor and its surroundings:
// command input, memory-mapped bus access, and response output.
interface vjtag_cmd_exec_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  localparam int CMD_W = 2 + AW + DW;
  localparam int RSP_W = 2 + DW;

  // valid/ready: a transfer happens on each clk edge where valid && ready;
  // the source holds valid and payload stable until that edge.
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CMD_W-1:0] cmd_payload;

  logic             bus_req;
  logic             bus_we;
  logic [AW-1:0]    bus_addr;
  logic [DW-1:0]    bus_wdata;
  logic             bus_ack;
  logic [DW-1:0]    bus_rdata;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [RSP_W-1:0] rsp_payload;

  modport master (
    input  cmd_valid, cmd_payload, bus_ack, bus_rdata, rsp_ready,
    output cmd_ready, bus_req, bus_we, bus_addr, bus_wdata, rsp_valid, rsp_payload
  );

  modport slave (
    output cmd_valid, cmd_payload, bus_ack, bus_rdata, rsp_ready,
    input  cmd_ready, bus_req, bus_we, bus_addr, bus_wdata, rsp_valid, rsp_payload
  );
endinterface

// File: rtl/vjtag_cmd_exec.sv
// Executes one decoded JTAG command at a time as a single req/ack bus access
// and returns a {status, rdata} response; a cycle counter bounds each access.
module vjtag_cmd_exec #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  vjtag_cmd_exec_if.master      io,
  output logic [1:0]            state_o
);
  localparam int CMD_W = 2 + AW + DW;
  localparam int RSP_W = 2 + DW;
  localparam int CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BAD_OP  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             bus_req_q, bus_req_d;
  logic             bus_we_q, bus_we_d;
  logic [AW-1:0]    bus_addr_q, bus_addr_d;
  logic [DW-1:0]    bus_wdata_q, bus_wdata_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [RSP_W-1:0] rsp_payload_q, rsp_payload_d;

  logic [1:0]       cmd_op;
  logic [AW-1:0]    cmd_addr;
  logic [DW-1:0]    cmd_wdata;

  assign cmd_op    = io.cmd_payload[CMD_W-1 -: 2];
  assign cmd_addr  = io.cmd_payload[DW +: AW];
  assign cmd_wdata = io.cmd_payload[DW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b1;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_payload_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_payload_q <= rsp_payload_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_ready_d   = cmd_ready_q;
    bus_req_d     = bus_req_q;
    bus_we_d      = bus_we_q;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_payload_d = rsp_payload_q;

    case (state_q)
      IDLE: begin
        if (io.cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          bus_addr_d  = cmd_addr;
          bus_wdata_d = cmd_wdata;
          if (cmd_op == OP_WRITE || cmd_op == OP_READ) begin
            state_d   = BUS;
            bus_req_d = 1'b1;
            bus_we_d  = (cmd_op == OP_WRITE);
          end else begin
            state_d       = RESP;
            rsp_valid_d   = 1'b1;
            rsp_payload_d = {(cmd_op == OP_NOP) ? ST_OK : ST_BAD_OP, {DW{1'b0}}};
          end
        end
      end

      BUS: begin
        cnt_d = cnt_q + 1'b1;
        // An ack in the final allowed cycle still completes the access.
        if (io.bus_ack) begin
          state_d       = RESP;
          bus_req_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_payload_d = {ST_OK, bus_we_q ? {DW{1'b0}} : io.bus_rdata};
        end else if (cnt_q == CNT_LAST) begin
          state_d       = RESP;
          bus_req_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_payload_d = {ST_TIMEOUT, {DW{1'b0}}};
        end
      end

      RESP: begin
        if (io.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          cnt_d       = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign io.cmd_ready   = cmd_ready_q;
  assign io.bus_req     = bus_req_q;
  assign io.bus_we      = bus_we_q;
  assign io.bus_addr    = bus_addr_q;
  assign io.bus_wdata   = bus_wdata_q;
  assign io.rsp_valid   = rsp_valid_q;
  assign io.rsp_payload = rsp_payload_q;
  assign state_o        = state_q;
endmodule

// File: tb/tb_vjtag_cmd_exec.sv
// Directed bench for vjtag_cmd_exec: write, read, timeout, NOP/illegal,
// backpressure with a held next command, and reset in the middle of an access.
module tb_vjtag_cmd_exec;
  localparam int AW      = 16;
  localparam int DW      = 32;
  localparam int TIMEOUT = 8;
  localparam int RSP_W   = 2 + DW;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int cycles;
  logic [RSP_W-1:0] exp_q[$];
  logic [RSP_W-1:0] held_payload;

  vjtag_cmd_exec_if #(.AW(AW), .DW(DW)) io ();

  vjtag_cmd_exec #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .rst     (rst),
    .io      (io.master),
    .state_o (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata);
    chk("cmd_ready_before_send", 64'(io.cmd_ready), 64'd1);
    io.cmd_valid   = 1'b1;
    io.cmd_payload = {op, addr, wdata};
    step();
    io.cmd_valid   = 1'b0;
  endtask

  task automatic pulse_ack(input logic [DW-1:0] rdata);
    io.bus_ack   = 1'b1;
    io.bus_rdata = rdata;
    step();
    io.bus_ack   = 1'b0;
    io.bus_rdata = '0;
  endtask

  // Scoreboard: compare the presented response with the oldest expectation, then hand it off.
  task automatic take_rsp(input string tag);
    logic [RSP_W-1:0] exp;
    chk({tag, "_rsp_valid"}, 64'(io.rsp_valid), 64'd1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : {RSP_W{1'bx}};
    chk({tag, "_rsp_payload"}, 64'(io.rsp_payload), 64'(exp));
    io.rsp_ready = 1'b1;
    step();
    io.rsp_ready = 1'b0;
    chk({tag, "_rsp_valid_after_hs"}, 64'(io.rsp_valid), 64'd0);
    chk({tag, "_cmd_ready_after_hs"}, 64'(io.cmd_ready), 64'd1);
  endtask

  initial begin
    io.cmd_valid   = 1'b0;
    io.cmd_payload = '0;
    io.bus_ack     = 1'b0;
    io.bus_rdata   = '0;
    io.rsp_ready   = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_cmd_ready", 64'(io.cmd_ready), 64'd1);
    chk("rst_bus_req", 64'(io.bus_req), 64'd0);
    chk("rst_bus_we", 64'(io.bus_we), 64'd0);
    chk("rst_bus_addr", 64'(io.bus_addr), 64'd0);
    chk("rst_bus_wdata", 64'(io.bus_wdata), 64'd0);
    chk("rst_rsp_valid", 64'(io.rsp_valid), 64'd0);
    chk("rst_rsp_payload", 64'(io.rsp_payload), 64'd0);
    chk("rst_state", 64'(state_dbg), 64'd0);

    // Write, slave acks in the third bus cycle
    send_cmd(2'b01, 16'h1234, 32'hDEADBEEF);
    exp_q.push_back({2'b00, 32'h0000_0000});
    chk("wr_bus_req_c1", 64'(io.bus_req), 64'd1);
    chk("wr_bus_we", 64'(io.bus_we), 64'd1);
    chk("wr_bus_addr", 64'(io.bus_addr), 64'h1234);
    chk("wr_bus_wdata", 64'(io.bus_wdata), 64'hDEADBEEF);
    chk("wr_cmd_ready_low", 64'(io.cmd_ready), 64'd0);
    step();
    chk("wr_bus_req_c2", 64'(io.bus_req), 64'd1);
    step();
    chk("wr_bus_req_c3", 64'(io.bus_req), 64'd1);
    chk("wr_rsp_valid_early", 64'(io.rsp_valid), 64'd0);
    pulse_ack(32'h1111_2222);
    chk("wr_bus_req_dropped", 64'(io.bus_req), 64'd0);
    take_rsp("wr");

    // Read, ack in the first bus cycle
    send_cmd(2'b10, 16'h0040, $urandom());
    exp_q.push_back({2'b00, 32'hCAFEF00D});
    chk("rd_bus_req_n1", 64'(io.bus_req), 64'd1);
    chk("rd_bus_we", 64'(io.bus_we), 64'd0);
    chk("rd_bus_addr", 64'(io.bus_addr), 64'h0040);
    chk("rd_cmd_ready_n1", 64'(io.cmd_ready), 64'd0);
    chk("rd_rsp_valid_n1", 64'(io.rsp_valid), 64'd0);
    pulse_ack(32'hCAFEF00D);
    chk("rd_cmd_ready_n2", 64'(io.cmd_ready), 64'd0);
    chk("rd_bus_req_n2", 64'(io.bus_req), 64'd0);
    take_rsp("rd");

    // Timeout: no ack, bus_req must stay high exactly TIMEOUT cycles
    send_cmd(2'b10, 16'h0100, 32'h0);
    exp_q.push_back({2'b10, 32'h0000_0000});
    cycles = 0;
    for (int i = 0; i < 4 * TIMEOUT && io.bus_req; i++) begin
      cycles++;
      step();
    end
    chk("to_req_cycles", 64'(cycles), 64'(TIMEOUT));
    chk("to_rsp_valid", 64'(io.rsp_valid), 64'd1);
    step();
    pulse_ack(32'hBAD0_BAD0);
    chk("to_late_ack_bus_req", 64'(io.bus_req), 64'd0);
    take_rsp("to");
    step();
    step();
    chk("to_no_second_rsp", 64'(io.rsp_valid), 64'd0);
    pulse_ack(32'hBAD1_BAD1);
    chk("idle_ack_no_rsp", 64'(io.rsp_valid), 64'd0);
    chk("idle_ack_cmd_ready", 64'(io.cmd_ready), 64'd1);

    // Ack in the last allowed cycle wins over timeout
    send_cmd(2'b10, 16'h0300, 32'h0);
    exp_q.push_back({2'b00, 32'hA5A5_5A5A});
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    chk("aw_bus_req_last", 64'(io.bus_req), 64'd1);
    pulse_ack(32'hA5A5_5A5A);
    take_rsp("ack_wins");

    // NOP and illegal opcode: response at N+1, never a bus request
    send_cmd(2'b00, 16'hFFFF, 32'h1234_5678);
    exp_q.push_back({2'b00, 32'h0000_0000});
    chk("nop_bus_req", 64'(io.bus_req), 64'd0);
    take_rsp("nop");
    send_cmd(2'b11, 16'hABCD, 32'h8765_4321);
    exp_q.push_back({2'b01, 32'h0000_0000});
    chk("bad_bus_req", 64'(io.bus_req), 64'd0);
    take_rsp("bad");
    chk("bad_bus_req_after", 64'(io.bus_req), 64'd0);

    // Backpressure with the next command held on cmd_valid
    send_cmd(2'b10, 16'h0080, 32'h0);
    exp_q.push_back({2'b00, 32'h1234_5678});
    pulse_ack(32'h1234_5678);
    held_payload = io.rsp_payload;
    io.cmd_valid   = 1'b1;
    io.cmd_payload = {2'b01, 16'h00AA, 32'h55AA_55AA};
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_rsp_valid", 64'(io.rsp_valid), 64'd1);
      chk("bp_rsp_stable", 64'(io.rsp_payload), 64'(held_payload));
      chk("bp_cmd_ready", 64'(io.cmd_ready), 64'd0);
    end
    take_rsp("bp");
    chk("bp_next_not_accepted", 64'(io.bus_req), 64'd0);
    step();
    io.cmd_valid = 1'b0;
    exp_q.push_back({2'b00, 32'h0000_0000});
    chk("b2b_bus_req", 64'(io.bus_req), 64'd1);
    chk("b2b_bus_we", 64'(io.bus_we), 64'd1);
    chk("b2b_bus_addr", 64'(io.bus_addr), 64'h00AA);
    chk("b2b_bus_wdata", 64'(io.bus_wdata), 64'h55AA55AA);
    pulse_ack(32'hFFFF_FFFF);
    take_rsp("b2b");

    // Reset while bus_req is high
    send_cmd(2'b10, 16'h0200, 32'h0BAD_0BAD);
    chk("mr_bus_req_before", 64'(io.bus_req), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_bus_req", 64'(io.bus_req), 64'd0);
    chk("mr_cmd_ready", 64'(io.cmd_ready), 64'd1);
    chk("mr_rsp_valid", 64'(io.rsp_valid), 64'd0);
    chk("mr_bus_addr", 64'(io.bus_addr), 64'd0);
    chk("mr_bus_wdata", 64'(io.bus_wdata), 64'd0);
    chk("mr_rsp_payload", 64'(io.rsp_payload), 64'd0);
    pulse_ack(32'h7777_7777);
    step();
    chk("mr_late_ack_rsp", 64'(io.rsp_valid), 64'd0);
    chk("mr_late_ack_req", 64'(io.bus_req), 64'd0);
    chk("mr_late_ack_ready", 64'(io.cmd_ready), 64'd1);

    chk("sb_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
